// File: rtl/multiport_regfile.sv
// Purpose : 2-write / 3-read register file with a self-clearing sweep after reset or CLR.
// Latency : reads are combinational; writes land on the rising edge and are visible next cycle
//           (or in the same cycle through the optional write-first bypass).
// Backpressure: READY low during the clear sweep; writes offered while READY is low are dropped.
//
// Ports:
//   CLK, RST_N        clock and asynchronous active-low reset
//   CLR               synchronous request to re-clear the whole file (honoured only in RUN)
//   WE1/WA1/WD1       write port 1
//   WE2/WA2/WD2       write port 2 (wins over port 1 on an address collision)
//   RA1..RA3/RD1..RD3 combinational read ports
//   READY             high once the file is zeroed and accepting writes
module multiport_regfile #(
  parameter int AWL     = 5,
  parameter int DWL     = 32,
  parameter int DEPTH   = 2**AWL,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CLR,
  input  logic           WE1,
  input  logic           WE2,
  input  logic [AWL-1:0] WA1,
  input  logic [AWL-1:0] WA2,
  input  logic [DWL-1:0] WD1,
  input  logic [DWL-1:0] WD2,
  input  logic [AWL-1:0] RA1,
  input  logic [AWL-1:0] RA2,
  input  logic [AWL-1:0] RA3,
  output logic [DWL-1:0] RD1,
  output logic [DWL-1:0] RD2,
  output logic [DWL-1:0] RD3,
  output logic           READY
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // One extra bit so DEPTH == 2**AWL is representable in the range compare.
  localparam logic [AWL:0]   DEPTH_W  = (AWL+1)'(DEPTH);
  localparam logic [AWL-1:0] CNT_LAST = AWL'(DEPTH-1);

  // An address is "live" if it maps to real storage that may hold a non-zero value.
  // Out-of-range addresses and (optionally) r0 are never written and always read as zero.
  function automatic logic addr_live(input logic [AWL-1:0] a);
    logic in_range;
    logic is_r0;
    in_range = ({1'b0, a} < DEPTH_W);
    is_r0    = (ZERO_R0 != 0) && (a == '0);
    return in_range && !is_r0;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [AWL-1:0] cnt_q,   cnt_d;
  logic           ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        // CLR is deliberately not looked at here: a running sweep is never restarted.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign READY = ready_q;

  // ---------------------------------------------------------------------------
  // Write qualification: only in RUN, only to live addresses.
  // ---------------------------------------------------------------------------
  logic run;
  logic wr1_en;
  logic wr2_en;

  assign run    = (state_q == ST_RUN);
  assign wr1_en = run && WE1 && addr_live(WA1);
  assign wr2_en = run && WE2 && addr_live(WA2);

  // ---------------------------------------------------------------------------
  // Storage. Not reset: the sweep that follows every reset zeroes it, and reads
  // are forced to zero until the sweep is complete, so stale contents never leak.
  // ---------------------------------------------------------------------------
  logic [DWL-1:0] mem_q [DEPTH];
  logic [DWL-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = '0;
    end else begin
      // Port 2 is applied last so it wins a same-address collision.
      if (wr1_en) mem_d[WA1] = WD1;
      if (wr2_en) mem_d[WA2] = WD2;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [AWL-1:0] ra [3];
  logic [DWL-1:0] rd [3];

  assign ra[0] = RA1;
  assign ra[1] = RA2;
  assign ra[2] = RA3;

  always_comb begin
    rd = '{default: '0};
    for (int p = 0; p < 3; p++) begin
      // Non-live addresses and the whole CLEAR phase read as zero; the bypass
      // sits inside the live check so r0 stays zero even when it is written.
      if (run && addr_live(ra[p])) begin
        rd[p] = mem_q[ra[p]];
        if (BYPASS != 0) begin
          if (wr2_en && (WA2 == ra[p])) begin
            rd[p] = WD2;
          end else if (wr1_en && (WA1 == ra[p])) begin
            rd[p] = WD1;
          end
        end
      end
    end
  end

  assign RD1 = rd[0];
  assign RD2 = rd[1];
  assign RD3 = rd[2];

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench for multiport_regfile: three instances share all inputs --
// write-first (default), read-first (BYPASS=0) and a short file (DEPTH=20).
module tb_multiport_regfile;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        we1, we2;
  logic [4:0]  wa1, wa2;
  logic [31:0] wd1, wd2;
  logic [4:0]  ra1, ra2, ra3;

  logic [31:0] rd1_a, rd2_a, rd3_a;
  logic [31:0] rd1_b, rd2_b, rd3_b;
  logic [31:0] rd1_s, rd2_s, rd3_s;
  logic        ready_a, ready_b, ready_s;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  multiport_regfile u_dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .WE1(we1), .WE2(we2), .WA1(wa1), .WA2(wa2), .WD1(wd1), .WD2(wd2),
    .RA1(ra1), .RA2(ra2), .RA3(ra3),
    .RD1(rd1_a), .RD2(rd2_a), .RD3(rd3_a), .READY(ready_a)
  );

  multiport_regfile #(.BYPASS(0)) u_dut_nb (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .WE1(we1), .WE2(we2), .WA1(wa1), .WA2(wa2), .WD1(wd1), .WD2(wd2),
    .RA1(ra1), .RA2(ra2), .RA3(ra3),
    .RD1(rd1_b), .RD2(rd2_b), .RD3(rd3_b), .READY(ready_b)
  );

  multiport_regfile #(.DEPTH(20)) u_dut_sm (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .WE1(we1), .WE2(we2), .WA1(wa1), .WA2(wa2), .WD1(wd1), .WD2(wd2),
    .RA1(ra1), .RA2(ra2), .RA3(ra3),
    .RD1(rd1_s), .RD2(rd2_s), .RD3(rd3_s), .READY(ready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until READY on the main instance, bounded at 100.
  // clr_at > 0 raises CLR for one edge after that many edges (mid-sweep).
  task automatic sweep_count(input int clr_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      clr = (clr_at != 0) && (cnt == clr_at);
      if (ready_a) break;
    end
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    we1 = 1'b0; we2 = 1'b0; wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    ra1 = '0; ra2 = '0; ra3 = '0;

    // Reset state
    tick;
    check_eq("rst_ready", {31'd0, ready_a}, 32'd0);
    check_eq("rst_rd1", rd1_a, 32'd0);
    check_eq("rst_rd2_nb", rd2_b, 32'd0);

    // Initial sweep: exactly 32 edges after release
    tick;
    rst_n = 1'b1;
    sweep_count(0, n);
    check_eq("init_sweep_edges", n, 32);
    check_eq("init_ready_small", {31'd0, ready_s}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a); ra3 = 5'(a);
      #1;
      check_eq("init_rd_zero", rd1_a, 32'd0);
    end
    tick;

    // Same-address collision, port 2 wins; bypass shows it in the write cycle
    we1 = 1; wa1 = 5; wd1 = 32'hAAAA0001;
    we2 = 1; wa2 = 5; wd2 = 32'hBBBB0002;
    ra1 = 5;
    #2;
    check_eq("collide_byp", rd1_a, 32'hBBBB0002);
    check_eq("collide_nobyp_old", rd1_b, 32'h0);
    tick;
    we1 = 0; we2 = 0;
    #2;
    check_eq("collide_stored", rd1_a, 32'hBBBB0002);
    check_eq("collide_stored_nb", rd1_b, 32'hBBBB0002);

    // Port-1-only bypass
    we1 = 1; wa1 = 9; wd1 = 32'h99; ra2 = 9;
    #2;
    check_eq("p1_byp", rd2_a, 32'h99);
    check_eq("p1_nobyp_old", rd2_b, 32'h0);
    tick;
    we1 = 0;
    #2;
    check_eq("p1_stored_nb", rd2_b, 32'h99);

    // Read-first: old value in write cycle, new value after
    we1 = 1; wa1 = 7; wd1 = 32'h1;
    tick;
    wd1 = 32'h12345678; ra2 = 7;
    #2;
    check_eq("rf_old", rd2_b, 32'h1);
    check_eq("wf_new", rd2_a, 32'h12345678);
    tick;
    we1 = 0;
    #2;
    check_eq("rf_new", rd2_b, 32'h12345678);

    // r0 hardwired to zero, including under bypass
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; ra3 = 0;
    #2;
    check_eq("r0_byp", rd3_a, 32'h0);
    check_eq("r0_nb", rd3_b, 32'h0);
    tick;
    we1 = 0;
    #2;
    check_eq("r0_after", rd3_a, 32'h0);

    // Out-of-range addresses on the DEPTH=20 file
    we1 = 1; wa1 = 25; wd1 = 32'h25;
    we2 = 1; wa2 = 19; wd2 = 32'h19;
    ra1 = 25; ra2 = 19;
    #2;
    check_eq("oor_byp_rd", rd1_s, 32'h0);
    check_eq("last_byp_rd", rd2_s, 32'h19);
    tick;
    we1 = 0; we2 = 0;
    #2;
    check_eq("oor_rd", rd1_s, 32'h0);
    check_eq("last_rd", rd2_s, 32'h19);
    check_eq("r25_full_depth", rd1_a, 32'h25);

    // CLR: sweep ignores writes and a repeated CLR, clears stored data
    we1 = 1; wa1 = 3; wd1 = 32'h55;
    tick;
    we1 = 0; ra1 = 3;
    #2;
    check_eq("r3_written", rd1_a, 32'h55);
    clr = 1;
    tick;
    clr = 0;
    check_eq("clr_ready_low", {31'd0, ready_a}, 32'd0);
    check_eq("clr_rd_forced0", rd1_a, 32'h0);
    we1 = 1; wa1 = 4; wd1 = 32'h44;
    sweep_count(5, n);
    we1 = 0;
    check_eq("clr_sweep_edges", n, 32);
    ra1 = 3; ra2 = 4;
    #2;
    check_eq("clr_r3_zero", rd1_a, 32'h0);
    check_eq("clr_r4_ignored", rd2_a, 32'h0);

    // Reset at counter 10 of a sweep restarts it from 0
    clr = 1;
    tick;
    clr = 0;
    repeat (10) tick;
    #2;
    rst_n = 0;
    #1;
    check_eq("midsweep_rst_ready", {31'd0, ready_a}, 32'd0);
    tick;
    check_eq("midsweep_rst_hold", {31'd0, ready_a}, 32'd0);
    rst_n = 1;
    sweep_count(0, n);
    check_eq("midsweep_restart_edges", n, 32);

    // Reset mid-RUN: outputs drop immediately, contents cleared after sweep
    we1 = 1; wa1 = 8; wd1 = 32'h88;
    tick;
    we1 = 0; ra1 = 8;
    #2;
    check_eq("r8_written", rd1_a, 32'h88);
    rst_n = 0;
    #1;
    check_eq("run_rst_rd0", rd1_a, 32'h0);
    check_eq("run_rst_ready", {31'd0, ready_a}, 32'd0);
    tick;
    rst_n = 1;
    sweep_count(0, n);
    check_eq("run_rst_edges", n, 32);
    #1;
    check_eq("r8_cleared", rd1_a, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
